// File: rtl/alu_issue_sched.sv
// ALU reservation station: one dispatch, one issue per cycle; define ISSUE_OLDEST_EN for oldest-ready issue (else lowest index).
// Dispatch-to-alu_en 2 cycles when ready; full blocks dispatch; rdy=0 stalls everything.
`ifndef ROB_POS_WID
`define ROB_POS_WID 4
`endif

module alu_issue_sched #(
    parameter int RS_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    in_valid,
    input  logic [10:0]             in_ctl,
    input  logic [31:0]             in_val1,
    input  logic [31:0]             in_val2,
    input  logic                    in_rdy1,
    input  logic                    in_rdy2,
    input  logic [`ROB_POS_WID-1:0] in_tag1,
    input  logic [`ROB_POS_WID-1:0] in_tag2,
    input  logic [31:0]             in_imm,
    input  logic [31:0]             in_pc,
    input  logic [`ROB_POS_WID-1:0] in_rob_pos,
    output logic                    full,
    input  logic                    cdb_valid,
    input  logic [`ROB_POS_WID-1:0] cdb_rob_pos,
    input  logic [31:0]             cdb_val,
    output logic                    alu_en,
    output logic [6:0]              alu_opcode,
    output logic [2:0]              alu_funct3,
    output logic                    alu_funct7,
    output logic [31:0]             alu_val1,
    output logic [31:0]             alu_val2,
    output logic [31:0]             alu_imm,
    output logic [31:0]             alu_pc,
    output logic [`ROB_POS_WID-1:0] alu_rob_pos
);
    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = $clog2(RS_SIZE + 1);
    localparam int TW = `ROB_POS_WID;

    logic [RS_SIZE-1:0] busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [10:0]        ctl_q [RS_SIZE], ctl_d [RS_SIZE];
    logic [31:0]        val1_q [RS_SIZE], val1_d [RS_SIZE];
    logic [31:0]        val2_q [RS_SIZE], val2_d [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE], imm_d [RS_SIZE];
    logic [31:0]        pc_q [RS_SIZE], pc_d [RS_SIZE];
    logic [TW-1:0]      tag1_q [RS_SIZE], tag1_d [RS_SIZE];
    logic [TW-1:0]      tag2_q [RS_SIZE], tag2_d [RS_SIZE];
    logic [TW-1:0]      pos_q [RS_SIZE], pos_d [RS_SIZE];
`ifdef ISSUE_OLDEST_EN
    localparam logic [IW-1:0] AGE_MAX = IW'(RS_SIZE - 1);
    logic [IW-1:0]      age_q [RS_SIZE], age_d [RS_SIZE];
    logic [IW-1:0]      best_age;
`endif

    logic               alu_en_q, alu_en_d;
    logic [10:0]        alu_ctl_q, alu_ctl_d;
    logic [31:0]        alu_val1_q, alu_val1_d, alu_val2_q, alu_val2_d;
    logic [31:0]        alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [TW-1:0]      alu_pos_q, alu_pos_d;

    logic [CW-1:0]      cnt;
    logic               free_vld, iss_vld, accept, cap1, cap2;
    logic [IW-1:0]      free_idx, iss_idx;

    always_comb begin
        cnt      = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt = cnt + CW'(busy_q[i]);
            if (!busy_q[i] && !free_vld) begin
                free_vld = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign full   = (cnt == CW'(RS_SIZE));
    assign accept = in_valid && !full && !rollback;

    // Selection only looks at registered ready bits, so a wakeup always costs one cycle.
    always_comb begin
        iss_vld = 1'b0;
        iss_idx = '0;
`ifdef ISSUE_OLDEST_EN
        best_age = '0;
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
`ifdef ISSUE_OLDEST_EN
                if (!iss_vld || age_q[i] > best_age) begin
                    iss_vld  = 1'b1;
                    iss_idx  = IW'(i);
                    best_age = age_q[i];
                end
`else
                if (!iss_vld) begin
                    iss_vld = 1'b1;
                    iss_idx = IW'(i);
                end
`endif
            end
        end
    end

    always_comb begin
        busy_d = busy_q;   rdy1_d = rdy1_q;   rdy2_d = rdy2_q;
        ctl_d  = ctl_q;    val1_d = val1_q;   val2_d = val2_q;
        imm_d  = imm_q;    pc_d   = pc_q;     pos_d  = pos_q;
        tag1_d = tag1_q;   tag2_d = tag2_q;
`ifdef ISSUE_OLDEST_EN
        age_d  = age_q;
`endif
        alu_en_d   = 1'b0;
        alu_ctl_d  = alu_ctl_q;
        alu_val1_d = alu_val1_q;
        alu_val2_d = alu_val2_q;
        alu_imm_d  = alu_imm_q;
        alu_pc_d   = alu_pc_q;
        alu_pos_d  = alu_pos_q;
        cap1 = !in_rdy1 && cdb_valid && (in_tag1 == cdb_rob_pos);
        cap2 = !in_rdy2 && cdb_valid && (in_tag2 == cdb_rob_pos);

        if (cdb_valid) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && !rdy1_q[i] && tag1_q[i] == cdb_rob_pos) begin
                    rdy1_d[i] = 1'b1;
                    val1_d[i] = cdb_val;
                end
                if (busy_q[i] && !rdy2_q[i] && tag2_q[i] == cdb_rob_pos) begin
                    rdy2_d[i] = 1'b1;
                    val2_d[i] = cdb_val;
                end
            end
        end

        if (iss_vld && !rollback) begin
            busy_d[iss_idx] = 1'b0;
            alu_en_d   = 1'b1;
            alu_ctl_d  = ctl_q[iss_idx];
            alu_val1_d = val1_q[iss_idx];
            alu_val2_d = val2_q[iss_idx];
            alu_imm_d  = imm_q[iss_idx];
            alu_pc_d   = pc_q[iss_idx];
            alu_pos_d  = pos_q[iss_idx];
        end

        // free_idx is never the issuing slot, so a freed slot only reopens next cycle.
        if (accept) begin
`ifdef ISSUE_OLDEST_EN
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
            end
            age_d[free_idx] = '0;
`endif
            busy_d[free_idx] = 1'b1;
            ctl_d[free_idx]  = in_ctl;
            rdy1_d[free_idx] = in_rdy1 | cap1;
            rdy2_d[free_idx] = in_rdy2 | cap2;
            val1_d[free_idx] = cap1 ? cdb_val : in_val1;
            val2_d[free_idx] = cap2 ? cdb_val : in_val2;
            tag1_d[free_idx] = in_tag1;
            tag2_d[free_idx] = in_tag2;
            imm_d[free_idx]  = in_imm;
            pc_d[free_idx]   = in_pc;
            pos_d[free_idx]  = in_rob_pos;
        end

        if (rollback) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            alu_en_q   <= 1'b0;
            alu_ctl_q  <= '0;
            alu_val1_q <= '0;
            alu_val2_q <= '0;
            alu_imm_q  <= '0;
            alu_pc_q   <= '0;
            alu_pos_q  <= '0;
`ifdef ISSUE_OLDEST_EN
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
`endif
        end else if (rdy) begin
            busy_q <= busy_d;   rdy1_q <= rdy1_d;   rdy2_q <= rdy2_d;
            ctl_q  <= ctl_d;    val1_q <= val1_d;   val2_q <= val2_d;
            imm_q  <= imm_d;    pc_q   <= pc_d;     pos_q  <= pos_d;
            tag1_q <= tag1_d;   tag2_q <= tag2_d;
`ifdef ISSUE_OLDEST_EN
            age_q  <= age_d;
`endif
            alu_en_q   <= alu_en_d;
            alu_ctl_q  <= alu_ctl_d;
            alu_val1_q <= alu_val1_d;
            alu_val2_q <= alu_val2_d;
            alu_imm_q  <= alu_imm_d;
            alu_pc_q   <= alu_pc_d;
            alu_pos_q  <= alu_pos_d;
        end
    end

    assign alu_en      = alu_en_q;
    assign alu_funct7  = alu_ctl_q[10];
    assign alu_funct3  = alu_ctl_q[9:7];
    assign alu_opcode  = alu_ctl_q[6:0];
    assign alu_val1    = alu_val1_q;
    assign alu_val2    = alu_val2_q;
    assign alu_imm     = alu_imm_q;
    assign alu_pc      = alu_pc_q;
    assign alu_rob_pos = alu_pos_q;
endmodule
